// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: FSM state encoding and counter-width helper shared by the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, with selectable reset value
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver presenting each good byte with a stretched ready level
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int READY_HOLD   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] uart_addr,
    output logic [7:0] uart_data,
    output logic       uart_ready,
    output logic       frame_error
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int RW = cnt_width(READY_HOLD + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic [RW-1:0] rdy_q, rdy_d;
    logic          ferr_q, ferr_d;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = (rdy_q != '0) ? rdy_q - 1'b1 : '0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    state_d = rx_s ? IDLE : BREAK;
                    data_d  = rx_s ? shift_q : data_q;
                    rdy_d   = rx_s ? RW'(READY_HOLD) : rdy_d;
                    ferr_d  = !rx_s;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign uart_data   = data_q;
    assign uart_addr   = data_q[7:4];
    assign uart_ready  = (rdy_q != '0);
    assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 16 clocks per bit, 4-cycle ready hold
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int HOLD = 4;
    // pin-to-ready: 2 sync + 1 idle + 8 half start + 9*16 bits + 1 output register
    localparam int LAT = 156;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [3:0] uart_addr;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       frame_error;

    uart_rx #(.CLKS_PER_BIT(CPB), .READY_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .uart_addr   (uart_addr),
        .uart_data   (uart_data),
        .uart_ready  (uart_ready),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0, rises = 0, ferrs = 0, ferr_hi = 0, hi_len = 0, last_hi = 0;
    int lo_len = 0, last_gap = 0, rise_cyc = 0, stab_err = 0;
    logic prev_rdy = 1'b0, prev_ferr = 1'b0, prev_rst = 1'b1;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (uart_ready && !prev_rdy) begin
            rises++;
            rise_cyc = cyc;
            last_gap = lo_len;
            lo_len = 0;
            hi_len = 0;
        end
        if (!uart_ready && prev_rdy) last_hi = hi_len;
        if (uart_ready) hi_len++;
        else lo_len++;
        if (frame_error) ferr_hi++;
        if (frame_error && !prev_ferr) ferrs++;
        if (uart_data !== prev_data && !(uart_ready && !prev_rdy) && !prev_rst) stab_err++;
        prev_rdy  = uart_ready;
        prev_ferr = frame_error;
        prev_data = uart_data;
        prev_rst  = rst;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop, output int t0);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            idle(bl);
        end
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         bitlen;
        logic [7:0] exp_data;
        logic [3:0] exp_addr;
    } vec_t;

    vec_t vecs[5];
    int r0, f0, fh0, t0;

    initial begin
        vecs[0] = '{8'hA5, 16, 8'hA5, 4'hA};
        vecs[1] = '{8'hC3, 17, 8'hC3, 4'hC};
        vecs[2] = '{8'h00, 16, 8'h00, 4'h0};
        vecs[3] = '{8'hFF, 16, 8'hFF, 4'hF};
        vecs[4] = '{8'h5A, 16, 8'h5A, 4'h5};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_data", uart_data, 8'h00);
        check("reset_addr", uart_addr, 4'h0);
        check("reset_ready", uart_ready, 1'b0);
        check("reset_ferr", frame_error, 1'b0);
        idle(4);

        for (int i = 0; i < 5; i++) begin
            r0 = rises;
            f0 = ferrs;
            send_frame(vecs[i].data, vecs[i].bitlen, 1'b1, t0);
            idle(40);
            check($sformatf("v%0d_data", i), uart_data, vecs[i].exp_data);
            check($sformatf("v%0d_addr", i), uart_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_rises", i), rises - r0, 1);
            check($sformatf("v%0d_hold", i), last_hi, HOLD);
            check($sformatf("v%0d_ferr", i), ferrs - f0, 0);
            check($sformatf("v%0d_latency", i), rise_cyc - t0, LAT);
        end

        r0 = rises;
        send_frame(8'h3C, CPB, 1'b1, t0);
        send_frame(8'h3F, CPB, 1'b1, t0);
        idle(40);
        check("b2b_rises", rises - r0, 2);
        check("b2b_gap_ok", last_gap >= CPB, 1);
        check("b2b_data", uart_data, 8'h3F);
        check("b2b_addr", uart_addr, 4'h3);

        r0 = rises;
        f0 = ferrs;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        check("glitch_rises", rises - r0, 0);
        check("glitch_ferr", ferrs - f0, 0);
        check("glitch_data", uart_data, 8'h3F);
        send_frame(8'h12, CPB, 1'b1, t0);
        idle(40);
        check("post_glitch_data", uart_data, 8'h12);
        check("post_glitch_addr", uart_addr, 4'h1);
        check("post_glitch_rises", rises - r0, 1);

        send_frame(8'h77, CPB, 1'b1, t0);
        idle(40);
        check("pre_break_data", uart_data, 8'h77);
        r0 = rises;
        f0 = ferrs;
        fh0 = ferr_hi;
        rx = 1'b0;
        idle(12 * CPB);
        rx = 1'b1;
        idle(40);
        check("break_ferr_pulses", ferrs - f0, 1);
        check("break_ferr_cycles", ferr_hi - fh0, 1);
        check("break_rises", rises - r0, 0);
        check("break_data", uart_data, 8'h77);
        send_frame(8'h55, CPB, 1'b1, t0);
        idle(40);
        check("post_break_data", uart_data, 8'h55);
        check("post_break_addr", uart_addr, 4'h5);

        r0 = rises;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB);
        idle(1);
        rst = 1'b1;
        rx  = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_data", uart_data, 8'h00);
        check("midrst_addr", uart_addr, 4'h0);
        check("midrst_ready", uart_ready, 1'b0);
        check("midrst_ferr", frame_error, 1'b0);
        idle(12 * CPB);
        check("midrst_rises", rises - r0, 0);
        send_frame(8'h81, CPB, 1'b1, t0);
        idle(40);
        check("post_rst_data", uart_data, 8'h81);
        check("post_rst_addr", uart_addr, 4'h8);
        check("post_rst_rises", rises - r0, 1);

        check("data_stability", stab_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
